pulse_stretch: RTL
==================

// Module: pulse_stretch
// PURPOSE
//  Converse of the one-cycle edge-pulse generator: turns single-cycle event pulses back into
//  level signals of programmable width, e.g. for driving LEDs or slow peripherals on the board.
//  Sits downstream of the edge-pulse stage or a counter tick. Guarantees a minimum low gap
//  between consecutive output levels, and optionally queues pulses that arrive while busy.
// PARAMETERS
//  WIDTH_W    8   bit width of width_cfg and of the internal duration counter
//  GAP_CYCLES 2   forced low cycles between consecutive output levels (0 = back-to-back allowed)
//  CNT_W      4   bit width of the pending-pulse counter (saturates at 2**CNT_W-1)
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  reset      in   1        asynchronous, active-high reset
//  pulse_in   in   1        single-cycle event; each high cycle counts as one event
//  width_cfg  in   WIDTH_W  high-time in cycles; sampled only when a level starts; 0 treated as 1
//  level_out  out  1        stretched output level (registered)
//  busy       out  1        high in HIGH or GAP state
//  pending    out  CNT_W    queued events not yet emitted (0 when queue compiled out)
//  overflow   out  1        sticky: an event was dropped; cleared only by reset
// BEHAVIOUR
//  - Reset (async, any state/time): state=IDLE, level_out=0, busy=0, pending=0, overflow=0,
//    counter=0. Reset mid-level aborts the level immediately; no queued events survive.
//  - FSM states IDLE, HIGH, GAP; all outputs registered.
//  - IDLE: pulse_in=1 at edge k -> HIGH, level_out=1 from cycle k+1, counter loaded with
//    max(width_cfg,1)-1. Latency pulse_in -> level_out = 1 cycle.
//  - HIGH: counter decrements each cycle; at 0 -> GAP if GAP_CYCLES>0, else directly to the
//    next-start decision. Exactly max(width_cfg,1) cycles of level_out=1.
//  - GAP: level_out=0 for exactly GAP_CYCLES cycles, then the next-start decision.
//  - Next-start decision: if pending>0 -> pending-1, reload from current width_cfg, enter HIGH
//    (level rises in the next cycle); else -> IDLE.
//  - busy = (state != IDLE), updated on the same edge as the state.
//  - pulse_in=1 while busy: handled per QUEUE option below.
//  - Simultaneous pulse_in and next-start decision with pending=0: the new event starts
//    immediately (no queue increment). With pending>0: pending stays unchanged (+1 -1).
//  - Saturation: pulse_in while pending==2**CNT_W-1 and not consumed that cycle -> event
//    dropped, overflow<=1; pending never wraps.
//  - width_cfg changes during HIGH do not affect the running level.
// CONFIGURATION
//  PULSE_STRETCH_QUEUE_EN defined: events arriving while busy increment pending, as above.
//  Not defined: events while busy are ignored and do not set overflow; pending tied to 0,
//    overflow tied to 0; the next-start decision always returns to IDLE.
// STRUCTURE
//  - Shared package pulse_pkg: typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_GAP} stretch_state_t;
//    plus default constants for WIDTH_W, GAP_CYCLES and CNT_W.
//  - One sub-module, stretch_counter: loadable down-counter (load, value, en -> zero flag),
//    instanced once and shared by the HIGH and GAP states.
//  - Top level holds the FSM, the pending counter and the overflow flag.
// TESTING
//  1. Reset: assert reset mid-HIGH at width_cfg=10 -> level_out, busy, pending, overflow = 0
//     on the same cycle; after release, idle until the next pulse_in.
//  2. Single event: width_cfg=5, one pulse_in at cycle 0 -> level_out high cycles 1..5,
//     low for cycles 6..7 (GAP=2), busy=0 from cycle 8.
//  3. width_cfg=0 -> exactly one cycle of level_out=1.
//  4. QUEUE_EN: width_cfg=3, three pulses in cycles 0,1,2 -> pending peaks at 2; three 3-cycle
//     levels, each separated by 2 low cycles; pending decrements at each start.
//  5. QUEUE_EN, CNT_W=2: width_cfg=20, 5 pulses while busy -> pending=3, overflow=1 and sticky.
//  6. No QUEUE_EN: same stimulus as test 4 -> a single 3-cycle level; pending=0, overflow=0.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and default sizing for the pulse stretcher.
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } stretch_state_t;

  localparam int WIDTH_W_DEF    = 8;
  localparam int GAP_CYCLES_DEF = 2;
  localparam int CNT_W_DEF      = 4;

endpackage

// File: rtl/pulse_stretch_if.sv
// Signal bundle between the event source and the pulse stretcher.
// pulse_in is a one-cycle strobe with no back-pressure: every high cycle is one event.
interface pulse_stretch_if
  import pulse_pkg::*;
#(
  parameter int WIDTH_W = WIDTH_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) ();

  logic               pulse_in;
  logic [WIDTH_W-1:0] width_cfg;
  logic               level_out;
  logic               busy;
  logic [CNT_W-1:0]   pending;
  logic               overflow;
  stretch_state_t     state;

  modport master (
    output pulse_in, width_cfg,
    input  level_out, busy, pending, overflow, state
  );

  modport slave (
    input  pulse_in, width_cfg,
    output level_out, busy, pending, overflow, state
  );

endinterface

// File: rtl/pulse_stretch_counter.sv
// Loadable down-counter shared by the HIGH and GAP phases; holds at zero.
module stretch_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle events into levels of programmable width with a forced low gap.
// Define PULSE_STRETCH_QUEUE_EN to queue events that arrive while busy.
module pulse_stretch
  import pulse_pkg::*;
#(
  parameter int WIDTH_W    = WIDTH_W_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic            clk,
  input logic            reset,
  pulse_stretch_if.slave bus
);

  localparam logic [WIDTH_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? WIDTH_W'(GAP_CYCLES - 1) : '0;

  stretch_state_t     state, state_nxt;
  logic               level_q, level_nxt;
  logic               busy_q, busy_nxt;
  logic               cnt_load, cnt_zero;
  logic [WIDTH_W-1:0] cnt_load_value, high_load;
  logic               decide;
`ifdef PULSE_STRETCH_QUEUE_EN
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  logic [CNT_W-1:0]   pend_q, pend_nxt;
  logic               ovf_q, ovf_nxt;
`endif

  // A zero width still produces one high cycle.
  assign high_load = (bus.width_cfg == '0) ? '0 : bus.width_cfg - 1'b1;

  stretch_counter #(.W(WIDTH_W)) u_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .value (cnt_load_value),
    .en    (state != ST_IDLE),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
      pend_q  <= '0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      level_q <= level_nxt;
      busy_q  <= busy_nxt;
`ifdef PULSE_STRETCH_QUEUE_EN
      pend_q  <= pend_nxt;
      ovf_q   <= ovf_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_load       = 1'b0;
    cnt_load_value = high_load;
    decide         = 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
    pend_nxt       = pend_q;
    ovf_nxt        = ovf_q;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.pulse_in) begin
          state_nxt = ST_HIGH;
          cnt_load  = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          if (GAP_CYCLES > 0) begin
            state_nxt      = ST_GAP;
            cnt_load       = 1'b1;
            cnt_load_value = GAP_LOAD;
          end else begin
            decide = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (cnt_zero) decide = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
`ifdef PULSE_STRETCH_QUEUE_EN
    // An event coinciding with the decision is consumed directly instead of being queued.
    if (decide) begin
      if ((pend_q != '0) || bus.pulse_in) begin
        state_nxt      = ST_HIGH;
        cnt_load       = 1'b1;
        cnt_load_value = high_load;
        if ((pend_q != '0) && !bus.pulse_in) pend_nxt = pend_q - 1'b1;
      end else begin
        state_nxt = ST_IDLE;
      end
    end else if ((state != ST_IDLE) && bus.pulse_in) begin
      if (pend_q == PEND_MAX) ovf_nxt = 1'b1;
      else                    pend_nxt = pend_q + 1'b1;
    end
`else
    if (decide) state_nxt = ST_IDLE;
`endif
  end

  always_comb begin
    level_nxt = (state_nxt == ST_HIGH);
    busy_nxt  = (state_nxt != ST_IDLE);
  end

  assign bus.level_out = level_q;
  assign bus.busy      = busy_q;
  assign bus.state     = state;
`ifdef PULSE_STRETCH_QUEUE_EN
  assign bus.pending   = pend_q;
  assign bus.overflow  = ovf_q;
`else
  assign bus.pending   = '0;
  assign bus.overflow  = 1'b0;
`endif

endmodule
